// File: rtl/instruction_fetch.sv
// Non-pipelined instruction fetch stage.
// Holds the PC, fetches one word at a time over a ready/valid memory
// handshake, latches it in the instruction register and keeps it there until
// the downstream datapath releases it. The next PC is then chosen from the
// jump, branch and zero decisions.
module instruction_fetch #(
  parameter int                  PC_WIDTH = 32,
  // Must be word aligned.
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rstN,
  output logic                imemReq,
  output logic [PC_WIDTH-1:0] imemAddr,
  input  logic                imemReady,
  input  logic [PC_WIDTH-1:0] imemData,
  input  logic                stall,
  input  logic                branch,
  input  logic                zero,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] branchOffset,
  input  logic [25:0]         jumpTarget,
  output logic [PC_WIDTH-1:0] instr,
  output logic                instrValid,
  output logic [5:0]          opCode,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pcPlus4
);

  // 6'h3F decodes to all-zero controls downstream, so it is a safe bubble.
  localparam logic [5:0] OP_BUBBLE = 6'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] instr_q;
  logic                instr_valid_q;
  logic                imem_req_q;

  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] jump_addr;

  assign pc_plus4      = pc_q + PC_WIDTH'(4);
  assign branch_target = pc_plus4 + (branchOffset << 2);
  // Region-relative jump: keep the top nibble of pc+4 (assumes PC_WIDTH > 28).
  assign jump_addr     = {pc_plus4[PC_WIDTH-1:28], jumpTarget, 2'b00};

  // Next-PC select: jump beats a taken branch, which beats sequential flow.
  always_comb begin
    pc_d = pc_plus4;
    if (jump) begin
      pc_d = jump_addr;
    end else if (branch && zero) begin
      pc_d = branch_target;
    end
  end

  // Fetch FSM with registered request, instruction register and PC.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
        end
        FETCH: begin
          // Request and address stay put until memory accepts.
          if (imemReady) begin
            instr_q       <= imemData;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          // Control inputs only matter on the cycle the instruction retires.
          if (!stall) begin
            pc_q          <= pc_d;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state_q       <= FETCH;
          end
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imemReq    = imem_req_q;
  assign imemAddr   = {pc_q[PC_WIDTH-1:2], 2'b00};
  assign instr      = instr_q;
  assign instrValid = instr_valid_q;
  assign opCode     = instr_valid_q ? instr_q[PC_WIDTH-1:PC_WIDTH-6] : OP_BUBBLE;
  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset state, sequential fetch,
// memory wait states, stall hold, a table of next-PC vectors, PC wrap at
// the top of the address space and an asynchronous reset mid-request.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rstN;
  logic        imemReady;
  logic [31:0] imemData;
  logic        stall, branch, zero, jump;
  logic [31:0] branchOffset;
  logic [25:0] jumpTarget;

  logic        req0, valid0, req1, valid1;
  logic [31:0] addr0, instr0, pc0, pcp0, addr1, instr1, pc1, pcp1;
  logic [5:0]  op0, op1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word content derived from its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {6'h23 ^ a[7:2], a[25:0] ^ 26'h155_5555};
  endfunction

  function automatic logic [5:0] op_of(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return w[31:26];
  endfunction

  assign imemData = mem_word(addr0);

  instruction_fetch #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rstN(rstN), .imemReq(req0), .imemAddr(addr0),
    .imemReady(imemReady), .imemData(imemData), .stall(stall),
    .branch(branch), .zero(zero), .jump(jump), .branchOffset(branchOffset),
    .jumpTarget(jumpTarget), .instr(instr0), .instrValid(valid0),
    .opCode(op0), .pc(pc0), .pcPlus4(pcp0)
  );

  // Second instance exercises wrap from the top of the address space.
  instruction_fetch #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rstN(rstN), .imemReq(req1), .imemAddr(addr1),
    .imemReady(imemReady), .imemData(mem_word(addr1)), .stall(stall),
    .branch(branch), .zero(zero), .jump(jump), .branchOffset(branchOffset),
    .jumpTarget(jumpTarget), .instr(instr1), .instrValid(valid1),
    .opCode(op1), .pc(pc1), .pcPlus4(pcp1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] start_pc;
    logic        br;
    logic        z;
    logic        j;
    logic [31:0] off;
    logic [25:0] jt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  // Starting in HOLD: jump to v.start_pc, fetch it, then retire it with the
  // vector's controls and check the next fetch address.
  task automatic run_vec(input vec_t v);
    logic [31:0] s;
    s = v.start_pc;
    jump = 1'b1;
    jumpTarget = s[27:2];
    tick;                                   // HOLD -> FETCH at start_pc
    jump = 1'b0;
    chk({v.name, "_start_addr"}, addr0, v.start_pc);
    // Controls applied during FETCH must be ignored until HOLD retires.
    branch = v.br; zero = v.z; jump = v.j;
    branchOffset = v.off; jumpTarget = v.jt;
    tick;                                   // FETCH -> HOLD
    chk({v.name, "_hold_pc"}, pc0, v.start_pc);
    tick;                                   // HOLD -> FETCH at next pc
    chk({v.name, "_next_addr"}, addr0, v.exp);
    chk({v.name, "_next_req"}, {31'd0, req0}, 32'd1);
    $display("vec %s: pc=%h br=%0d z=%0d j=%0d off=%h jt=%h -> addr=%h (exp %h)",
             v.name, v.start_pc, v.br, v.z, v.j, v.off, v.jt, addr0, v.exp);
    branch = 1'b0; zero = 1'b0; jump = 1'b0; branchOffset = '0; jumpTarget = '0;
    tick;                                   // FETCH -> HOLD at exp
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"br_taken",   32'h0000_0010, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0,        32'h0000_000C};
    vecs[1] = '{"br_nozero",  32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0,        32'h0000_0014};
    vecs[2] = '{"jmp_over_br",32'h0040_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0005, 26'h000_0010, 32'h0000_0040};
    vecs[3] = '{"zero_only",  32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0000_0003, 26'h0,        32'h0000_0104};
    vecs[4] = '{"br_fwd",     32'h0000_0100, 1'b1, 1'b1, 1'b0, 32'h0000_0003, 26'h0,        32'h0000_0110};
    vecs[5] = '{"br_self",    32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 26'h0,        32'h0000_0000};
    vecs[6] = '{"br_wrap",    32'h0000_0004, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0, 26'h0,        32'hFFFF_FFC8};

    rstN = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    branchOffset = '0; jumpTarget = '0; imemReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_req",    {31'd0, req0},   32'd0);
    chk("rst_addr",   addr0,           32'h0);
    chk("rst_pc",     pc0,             32'h0);
    chk("rst_pcp4",   pcp0,            32'h4);
    chk("rst_instr",  instr0,          32'h0);
    chk("rst_valid",  {31'd0, valid0}, 32'd0);
    chk("rst_op",     {26'd0, op0},    32'h3F);
    chk("rst1_addr",  addr1,           32'hFFFF_FFFC);
    chk("rst1_pcp4",  pcp1,            32'h0);
    $display("reset: req=%0d addr=%h pc=%h op=%h", req0, addr0, pc0, op0);

    // Reset release: IDLE for one clock, then fetch at RESET_PC
    rstN = 1'b1;
    tick;
    chk("f0_req",   {31'd0, req0},   32'd1);
    chk("f0_addr",  addr0,           32'h0);
    chk("f0_op",    {26'd0, op0},    32'h3F);
    chk("f0_1addr", addr1,           32'hFFFF_FFFC);
    tick;
    chk("h0_req",   {31'd0, req0},   32'd0);
    chk("h0_valid", {31'd0, valid0}, 32'd1);
    chk("h0_instr", instr0,          mem_word(32'h0));
    chk("h0_op",    {26'd0, op0},    {26'd0, op_of(32'h0)});
    chk("h0_1pcp4", pcp1,            32'h0);
    $display("fetch: addr=%h instr=%h op=%h", pc0, instr0, op0);
    tick;
    chk("f4_addr",  addr0,           32'h4);
    chk("f4_valid", {31'd0, valid0}, 32'd0);
    chk("f4_op",    {26'd0, op0},    32'h3F);
    chk("f4_1wrap", addr1,           32'h0);
    tick;
    chk("h4_instr", instr0,          mem_word(32'h4));

    // Three wait states at 0x8
    imemReady = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("w8_req",  {31'd0, req0}, 32'd1);
      chk("w8_addr", addr0,         32'h8);
      if (i == 3) imemReady = 1'b1;
      tick;
    end
    chk("h8_req",   {31'd0, req0}, 32'd0);
    chk("h8_instr", instr0,        mem_word(32'h8));
    chk("h8_pc",    pc0,           32'h8);
    $display("wait fetch: addr=%h instr=%h", pc0, instr0);

    // Stall at 0x10 for five cycles
    tick; tick;                             // fetch/hold 0xC
    tick;                                   // fetch 0x10
    stall = 1'b1;
    tick;                                   // hold 0x10
    for (int i = 0; i < 5; i++) begin
      chk("st_pc",    pc0,           32'h10);
      chk("st_instr", instr0,        mem_word(32'h10));
      chk("st_op",    {26'd0, op0},  {26'd0, op_of(32'h10)});
      chk("st_req",   {31'd0, req0}, 32'd0);
      tick;
    end
    stall = 1'b0;
    tick;
    chk("st_rel_addr", addr0, 32'h14);
    $display("stall release: addr=%h", addr0);

    // Async reset during a wait at 0x20
    tick; tick; tick; tick; tick;           // hold 14, f/h 18, f/h 1C
    imemReady = 1'b0;
    tick;
    chk("w20_addr", addr0, 32'h20);
    tick;
    chk("w20_req",  {31'd0, req0}, 32'd1);
    #2 rstN = 1'b0;
    #1;
    chk("ar_req",   {31'd0, req0},   32'd0);
    chk("ar_valid", {31'd0, valid0}, 32'd0);
    chk("ar_pc",    pc0,             32'h0);
    chk("ar_addr",  addr0,           32'h0);
    imemReady = 1'b1;
    tick; tick;
    chk("ar_instr", instr0, 32'h0);
    rstN = 1'b1;
    tick;
    chk("ar_rf_addr",  addr0,         32'h0);
    chk("ar_rf_req",   {31'd0, req0}, 32'd1);
    chk("ar_rf_instr", instr0,        32'h0);
    tick;
    chk("ar_h_instr",  instr0,        mem_word(32'h0));
    $display("async reset: refetch addr=%h instr=%h", pc0, instr0);

    // Next-PC vectors
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of ControlUnit: holds the PC, requests instructions over a ready/valid instruction-memory handshake, and latches each returned word in an instruction register.
- Drives opCode (instr[31:26]) into ControlUnit.
- Consumes ControlUnit's branch/jump decisions plus ALU zero to select the next PC.
- Non-pipelined: one instruction in flight; the next fetch starts only after the downstream datapath releases the current one.

Parameters:
- PC_WIDTH, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h0000_0000, PC after reset; must be a multiple of 4.

Ports:
- clk  input  1  rising-edge clock
- rstN  input  1  asynchronous active-low reset
- imemReq  output  1  fetch request valid
- imemAddr  output  PC_WIDTH  byte address of requested word
- imemReady  input  1  memory accepts request and returns imemData this cycle
- imemData  input  PC_WIDTH  instruction word, valid when imemReq&&imemReady
- stall  input  1  downstream not done with current instruction
- branch  input  1  from ControlUnit
- zero  input  1  ALU zero flag
- jump  input  1  from ControlUnit
- branchOffset  input  PC_WIDTH  sign-extended immediate (word units)
- jumpTarget  input  26  instr[25:0]
- instr  output  PC_WIDTH  instruction register
- instrValid  output  1  instr holds a live instruction
- opCode  output  6  to ControlUnit
- pc  output  PC_WIDTH  address of instr
- pcPlus4  output  PC_WIDTH  pc+4

Behaviour:
- Reset (async, rstN=0): state IDLE, pc=RESET_PC, instr=0, instrValid=0, imemReq=0, imemAddr=RESET_PC, pcPlus4=RESET_PC+4, opCode=6'h3F. Takes effect immediately, mid-request or mid-hold; any outstanding request is abandoned and its data never latched.
- States:
  - IDLE: first clock after rstN rises -> FETCH.
  - FETCH: imemReq=1, imemAddr=pc, both stable until handshake. On imemReq&&imemReady: instr<=imemData, instrValid<=1, -> HOLD. Otherwise stay, outputs unchanged. Fetch latency is 1 cycle minimum (ready in the first FETCH cycle); each extra wait cycle adds 1.
  - HOLD: imemReq=0, instr/pc stable.
    - stall=1: stay.
    - stall=0: pc<=nextPc, instrValid<=0, -> FETCH.
- imemReady outside FETCH is ignored.
- Control sampling: branch, zero, jump and branchOffset are sampled only on the HOLD->FETCH edge; they are ignored in every other state.
- nextPc, priority jump > taken branch > sequential:
  - jump=1: {pcPlus4[31:28], jumpTarget, 2'b00}
  - branch&&zero: pcPlus4 + (branchOffset<<2)
  - else: pcPlus4
- Arithmetic is modulo 2^PC_WIDTH; overflow and wrap are silent. 32'hFFFF_FFFC+4 = 0.
- pcPlus4 = pc+4, combinational.
- opCode = instrValid ? instr[31:26] : 6'h3F. 6'h3F is an undefined opcode that decodes to all-zero controls, giving a bubble with no regWrite/memWrite.
- imemAddr[1:0] is always 2'b00.
- Throughput: 1 instruction per 2 cycles at best (FETCH, HOLD).

Test Plan:
- Reset release, imemReady=1, stall=0 -> imemReq high the 2nd cycle after rstN rises with imemAddr=0; subsequent addresses 0x4, 0x8, 0xC, one fetch per 2 cycles; opCode=6'h3F whenever instrValid=0.
- imemReady delayed 3 cycles at addr 0x8 -> imemReq/imemAddr=0x8 held 4 cycles; instr=imemData from the ready cycle; no extra fetch issued.
- pc=0x10 held with stall=1 for 5 cycles -> instr/pc/opCode stable, imemReq=0; release -> fetch at 0x14.
- pc=0x10, branch=1, zero=1, branchOffset=-2 -> next fetch 0x0C; same with zero=0 -> 0x14; jump=1 and branch=1 together, pc=0x0040_0000, jumpTarget=26'h000_0010 -> 0x0000_0040.
- RESET_PC=32'hFFFF_FFFC, sequential advance -> next imemAddr=0x0000_0000.
- rstN pulsed low during FETCH wait at 0x20 -> imemReq drops immediately, instrValid=0, pc=RESET_PC; memory data arriving afterwards is not latched; fetch restarts at RESET_PC.
